// File: rtl/snn_lif_layer_seq.sv
// Time-multiplexed leaky integrate-and-fire layer with binary (+1/-1) weights.
// One neuron is evaluated per clock through a shared popcount/accumulate path.
// Optional feature macro: SNN_SPIKE_COUNT_EN adds per-neuron saturating spike
// counters (spike_count_o) and a registered arg-max index (winner_o).
module snn_lif_layer_seq #(
    parameter int unsigned INPUTS        = 16,
    parameter int unsigned NEURONS       = 16,
    parameter int unsigned MEMBRANE_BITS = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    input  logic [INPUTS-1:0]          inputs_i,
    input  logic [MEMBRANE_BITS-2:0]   threshold_i,
    input  logic [2:0]                 shift_i,
    input  logic                       clear_state_i,
    input  logic                       cfg_valid_i,
    input  logic [7:0]                 cfg_data_i,
    output logic                       cfg_ready_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [NEURONS-1:0]         spikes_o
`ifdef SNN_SPIKE_COUNT_EN
    ,
    output logic [NEURONS*8-1:0]       spike_count_o,
    output logic [$clog2(NEURONS)-1:0] winner_o
`endif
);

    localparam int unsigned WEIGHTS = INPUTS * NEURONS;
    localparam int unsigned IDX_W   = $clog2(NEURONS);
    // Two guard bits: u - leak + syn never exceeds MEMBRANE_BITS+1 bits.
    localparam int unsigned SUM_W   = MEMBRANE_BITS + 2;

    localparam logic [IDX_W-1:0]        LastIdx = IDX_W'(NEURONS - 1);
    localparam logic signed [SUM_W-1:0] MaxV    = SUM_W'((1 << (MEMBRANE_BITS - 1)) - 1);
    localparam logic signed [SUM_W-1:0] MinV    = ~MaxV;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     latch_en;
    logic                     clear_en;
    logic [INPUTS-1:0]        inputs_q;
    logic [MEMBRANE_BITS-2:0] thr_q;
    logic [2:0]               shift_q;
    logic [WEIGHTS-1:0]       weights_q;
    logic signed [MEMBRANE_BITS-1:0] mem_q [NEURONS];
    logic [NEURONS-1:0]       shadow_q, shadow_d;
    logic [NEURONS-1:0]       spikes_q;

    // Datapath signals for the neuron currently selected by idx_q
    logic [INPUTS-1:0]               w_cur;
    logic signed [MEMBRANE_BITS-1:0] u_cur;
    logic signed [SUM_W-1:0]         u_ext, syn, leak, v_full, v_sat, thr_ext;
    logic                            spike;
    logic signed [MEMBRANE_BITS-1:0] u_next;

    assign clear_en = (state_q == StIdle) && clear_state_i && !start_i;
    assign spikes_o = spikes_q;

    // Next-state and handshake/status outputs
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        latch_en    = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        cfg_ready_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                cfg_ready_o = !start_i;
                if (start_i) begin
                    latch_en = 1'b1;
                    idx_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                busy_o = 1'b1;
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, neuron index and per-timestep latched operands
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            inputs_q <= '0;
            thr_q    <= '0;
            shift_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (latch_en) begin
                inputs_q <= inputs_i;
                thr_q    <= threshold_i;
                shift_q  <= shift_i;
            end
        end
    end

    // Weight shift register; the first byte of a full load ends at the bottom
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            weights_q <= '1;
        end else if (cfg_valid_i && cfg_ready_o) begin
            weights_q <= {cfg_data_i, weights_q[WEIGHTS-1:8]};
        end
    end

    // Shared LIF datapath: weighted sum, leak, saturate, threshold
    always_comb begin
        w_cur = '0;
        for (int n = 0; n < NEURONS; n++) begin
            if (idx_q == IDX_W'(n)) w_cur = weights_q[INPUTS*n +: INPUTS];
        end
        u_cur = mem_q[idx_q];
        u_ext = {{(SUM_W - MEMBRANE_BITS){u_cur[MEMBRANE_BITS-1]}}, u_cur};

        syn = '0;
        for (int j = 0; j < INPUTS; j++) begin
            if (inputs_q[j]) syn = w_cur[j] ? syn + SUM_W'(1) : syn - SUM_W'(1);
        end

        // Kept as if/else so the shift stays in a signed (arithmetic) context
        if (shift_q != 3'd0) begin
            leak = u_ext >>> shift_q;
        end else begin
            leak = '0;
        end

        v_full = u_ext - leak + syn;
        if (v_full > MaxV) begin
            v_sat = MaxV;
        end else if (v_full < MinV) begin
            v_sat = MinV;
        end else begin
            v_sat = v_full;
        end

        thr_ext = {{(SUM_W - MEMBRANE_BITS + 1){1'b0}}, thr_q};
        spike   = (v_sat >= thr_ext);
        u_next  = spike ? MEMBRANE_BITS'(v_sat - thr_ext) : MEMBRANE_BITS'(v_sat);

        shadow_d        = shadow_q;
        shadow_d[idx_q] = spike;
    end

    // Membrane storage: written only by the running neuron or a clear
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int n = 0; n < NEURONS; n++) mem_q[n] <= '0;
        end else if (state_q == StRun) begin
            mem_q[idx_q] <= u_next;
        end else if (clear_en) begin
            for (int n = 0; n < NEURONS; n++) mem_q[n] <= '0;
        end
    end

    // Shadow spike vector; published on the edge that enters StDone
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            shadow_q <= '0;
            spikes_q <= '0;
        end else if (state_q == StRun) begin
            shadow_q <= shadow_d;
            if (idx_q == LastIdx) spikes_q <= shadow_d;
        end
    end

`ifdef SNN_SPIKE_COUNT_EN
    logic [7:0]       cnt_q [NEURONS];
    logic [IDX_W-1:0] winner_q, winner_d;
    logic [7:0]       best;

    // Saturating per-neuron spike counters
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int n = 0; n < NEURONS; n++) cnt_q[n] <= '0;
        end else if (clear_en) begin
            for (int n = 0; n < NEURONS; n++) cnt_q[n] <= '0;
        end else if (state_q == StRun && spike && cnt_q[idx_q] != 8'hFF) begin
            cnt_q[idx_q] <= cnt_q[idx_q] + 8'd1;
        end
    end

    // Arg-max of counts; strict compare keeps the lowest index on ties
    always_comb begin
        winner_d = '0;
        best     = cnt_q[0];
        for (int n = 1; n < NEURONS; n++) begin
            if (cnt_q[n] > best) begin
                best     = cnt_q[n];
                winner_d = IDX_W'(n);
            end
        end
        for (int n = 0; n < NEURONS; n++) spike_count_o[8*n +: 8] = cnt_q[n];
    end

    // Winner register, refreshed once per timestep
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            winner_q <= '0;
        end else if (state_q == StDone) begin
            winner_q <= winner_d;
        end
    end

    assign winner_o = winner_q;
`endif

endmodule

// File: tb/tb_snn_lif_layer_seq.sv
// Self-checking bench for snn_lif_layer_seq with a behavioural LIF model.
module tb_snn_lif_layer_seq;
    localparam int NI = 16;
    localparam int NN = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, clear_state, cfg_valid;
    logic [NI-1:0] inputs;
    logic [6:0]    threshold;
    logic [2:0]    shift;
    logic [7:0]    cfg_data;
    logic          cfg_ready, busy, done;
    logic [NN-1:0] spikes;
`ifdef SNN_SPIKE_COUNT_EN
    logic [NN*8-1:0] spike_count;
    logic [3:0]      winner;
`endif

    snn_lif_layer_seq #(.INPUTS(NI), .NEURONS(NN), .MEMBRANE_BITS(8)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .inputs_i     (inputs),
        .threshold_i  (threshold),
        .shift_i      (shift),
        .clear_state_i(clear_state),
        .cfg_valid_i  (cfg_valid),
        .cfg_data_i   (cfg_data),
        .cfg_ready_o  (cfg_ready),
        .busy_o       (busy),
        .done_o       (done),
        .spikes_o     (spikes)
`ifdef SNN_SPIKE_COUNT_EN
        ,
        .spike_count_o(spike_count),
        .winner_o     (winner)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int            mem_m [NN];
    int            cnt_m [NN];
    int            win_m;
    logic [NN*NI-1:0] w_m;
    logic [NN-1:0] spk_m;
    logic [7:0]    bytes_m [32];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int n = 0; n < NN; n++) begin
            mem_m[n] = 0;
            cnt_m[n] = 0;
        end
        win_m = 0;
        w_m   = '1;
        spk_m = '0;
    endfunction

    function automatic void model_clear();
        for (int n = 0; n < NN; n++) begin
            mem_m[n] = 0;
            cnt_m[n] = 0;
        end
    endfunction

    // One timestep: integer arithmetic straight from the neuron equations
    function automatic void model_step(input logic [NI-1:0] in, input int thr, input int sh);
        int syn, leak, v, best;
        for (int n = 0; n < NN; n++) begin
            syn = 0;
            for (int j = 0; j < NI; j++)
                if (in[j]) syn += w_m[NI*n + j] ? 1 : -1;
            leak = (sh == 0) ? 0 : (mem_m[n] >>> sh);
            v = mem_m[n] - leak + syn;
            if (v > 127) v = 127;
            if (v < -128) v = -128;
            if (v >= thr) begin
                spk_m[n] = 1'b1;
                mem_m[n] = v - thr;
                if (cnt_m[n] < 255) cnt_m[n]++;
            end else begin
                spk_m[n] = 1'b0;
                mem_m[n] = v;
            end
        end
        best = -1;
        for (int n = 0; n < NN; n++)
            if (cnt_m[n] > best) begin
                best  = cnt_m[n];
                win_m = n;
            end
    endfunction

    task automatic check_counts(input string tag);
`ifdef SNN_SPIKE_COUNT_EN
        logic [NN*8-1:0] exp_cnt;
        for (int n = 0; n < NN; n++) exp_cnt[8*n +: 8] = 8'(cnt_m[n]);
        chk({tag, "_count"}, spike_count, exp_cnt);
        chk({tag, "_winner"}, winner, 4'(win_m));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // Full 32-byte weight load; byte k ends up at bits [8k+:8]
    task automatic load_weights();
        for (int k = 0; k < 32; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = bytes_m[k];
            #1;
            if (k == 0) chk("cfg_ready_idle", cfg_ready, 1'b1);
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
        for (int k = 0; k < 32; k++) w_m[8*k +: 8] = bytes_m[k];
    endtask

    task automatic do_clear();
        clear_state = 1'b1;
        @(posedge clk); #1;
        clear_state = 1'b0;
        model_clear();
    endtask

    // One timestep; optional start pulse while busy and cfg_valid alongside start
    task automatic step(input string tag, input logic [NI-1:0] in, input int thr, input int sh,
                        input bit poke, input bit clash);
        int nb;
        bit stable, early_done;
        start     = 1'b1;
        inputs    = in;
        threshold = 7'(thr);
        shift     = 3'(sh);
        if (clash) begin
            cfg_valid = 1'b1;
            cfg_data  = 8'h5A;
            #1;
            chk({tag, "_cfg_ready_start"}, cfg_ready, 1'b0);
        end
        @(posedge clk); #1;
        start     = 1'b0;
        cfg_valid = 1'b0;
        inputs    = ~in;
        threshold = 7'd0;
        shift     = 3'd0;
        nb = 0;
        stable = 1'b1;
        early_done = 1'b0;
        for (int c = 1; c <= NN; c++) begin
            if (busy === 1'b1) nb++;
            if (spikes !== spk_m) stable = 1'b0;
            if (done !== 1'b0) early_done = 1'b1;
            if (poke && c == 4) begin
                start  = 1'b1;
                inputs = '1;
            end
            if (poke && c == 5) start = 1'b0;
            @(posedge clk); #1;
        end
        model_step(in, thr, sh);
        chk({tag, "_busy_cycles"}, nb, NN);
        chk({tag, "_spikes_stable"}, stable, 1'b1);
        chk({tag, "_no_early_done"}, early_done, 1'b0);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy_off"}, busy, 1'b0);
        chk({tag, "_spikes"}, spikes, spk_m);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 1'b0);
        check_counts(tag);
    endtask

    initial begin
        int dcount;
        reset = 1'b1; start = 1'b0; clear_state = 1'b0; cfg_valid = 1'b0;
        inputs = '0; threshold = '0; shift = '0; cfg_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_spikes", spikes, '0);
        check_counts("rst");
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_cfg_ready", cfg_ready, 1'b1);

        // Basic firing, then sub-threshold residue
        step("basic1", 16'h000F, 3, 0, 0, 0);
        step("basic2", 16'h0000, 3, 0, 0, 0);
        // Start while busy ignored; cfg byte with start refused
        step("poke", 16'h00F0, 2, 0, 1, 1);

        // All -1 weights: deep negative saturation without wrap
        for (int k = 0; k < 32; k++) bytes_m[k] = 8'h00;
        load_weights();
        do_clear();
        for (int s = 0; s < 10; s++) step("negsat", 16'hFFFF, 127, 0, 0, 0);
        for (int k = 0; k < 32; k++) bytes_m[k] = 8'hFF;
        load_weights();
        step("negwrap", 16'hFFFF, 1, 0, 0, 0);

        // Positive saturation: 128 clips to 127 and fires at step 8
        do_clear();
        for (int s = 0; s < 9; s++) step("possat", 16'hFFFF, 127, 0, 0, 0);

        // Leak: 4, 6, 7, 8 then fire with threshold 8
        do_clear();
        for (int s = 0; s < 4; s++) step("leak", 16'h000F, 127, 1, 0, 0);
        step("leakfire", 16'h000F, 8, 1, 0, 0);

        // Randomized weights and timesteps
        for (int k = 0; k < 32; k++) bytes_m[k] = 8'($urandom);
        load_weights();
        do_clear();
        for (int s = 0; s < 14; s++) begin
            if ($urandom_range(0, 4) == 0) do_clear();
            step("rand", 16'($urandom), int'($urandom_range(1, 24)), int'($urandom_range(0, 3)),
                 0, 0);
        end

        // Reset in the middle of a timestep
        for (int k = 0; k < 32; k++) bytes_m[k] = 8'h00;
        load_weights();
        start = 1'b1; inputs = 16'h000F; threshold = 7'd3; shift = 3'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_spikes", spikes, '0);
        check_counts("midrst");
        @(posedge clk); #1;
        reset = 1'b0;
        dcount = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dcount++;
        end
        chk("midrst_no_done", dcount, 0);
        step("postrst", 16'h000F, 3, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
